// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN streaming blocks.
// Holds the unflattening FSM state type and the counter width function.
package cnn_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } unflat_state_t;

  // A counter that must reach n-1 is given one guard bit above $clog2(n).
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/unflat_seq.sv
// Cascaded cycle/pixel/group counters for the unflattening replay.
// The counters advance only while run_i is high, and clear_i restarts them at zero.
module unflat_seq
  import cnn_pkg::*;
#(
  parameter  int CyclesPerPixel = 4,
  parameter  int ImageSize      = 9,
  parameter  int NumGroups      = 2,
  localparam int CW             = cnt_w(CyclesPerPixel),
  localparam int PW             = cnt_w(ImageSize),
  localparam int GW             = cnt_w(NumGroups)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          clear_i,
  input  logic          run_i,
  output logic [PW-1:0] pix_o,
  output logic [GW-1:0] grp_o,
  output logic          cyc_zero_o,
  output logic          last_o
);

  localparam logic [CW-1:0] CYC_MAX = CW'(CyclesPerPixel - 1);
  localparam logic [PW-1:0] PIX_MAX = PW'(ImageSize - 1);
  localparam logic [GW-1:0] GRP_MAX = GW'(NumGroups - 1);

  logic [CW-1:0] cyc_q, cyc_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [GW-1:0] grp_q, grp_d;
  logic          cyc_wrap, pix_wrap, grp_wrap;

  assign cyc_wrap = (cyc_q == CYC_MAX);
  assign pix_wrap = (pix_q == PIX_MAX);
  assign grp_wrap = (grp_q == GRP_MAX);

  // NOTE: every signal written here is given a hold value first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    cyc_d = cyc_q;
    pix_d = pix_q;
    grp_d = grp_q;
    if (clear_i) begin
      cyc_d = '0;
      pix_d = '0;
      grp_d = '0;
    end else if (run_i) begin
      cyc_d = cyc_wrap ? '0 : cyc_q + CW'(1);
      if (cyc_wrap) pix_d = pix_wrap ? '0 : pix_q + PW'(1);
      if (cyc_wrap && pix_wrap) grp_d = grp_wrap ? '0 : grp_q + GW'(1);
    end
  end

  // NOTE: state registers take non-blocking assignments, so every flop samples its pre-edge inputs.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cyc_q <= '0;
      pix_q <= '0;
      grp_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      pix_q <= pix_d;
      grp_q <= grp_d;
    end
  end

  assign pix_o      = pix_q;
  assign grp_o      = grp_q;
  assign cyc_zero_o = (cyc_q == '0);
  assign last_o     = cyc_wrap && pix_wrap && grp_wrap;

endmodule

// File: rtl/unflattening_layer.sv
// Captures a flat activation vector and replays it as per-image raster streams.
// The replay uses NumOfOutputs lanes and holds each pixel for CyclesPerPixel cycles.
module unflattening_layer
  import cnn_pkg::*;
#(
  parameter int BitSize        = 2,
  parameter int ImageSize      = 9,
  parameter int NumOfImages    = 4,
  parameter int NumOfOutputs   = 2,
  parameter int CyclesPerPixel = 4
) (
  input  logic                                          clk,
  input  logic                                          res,
  input  logic                                          in_valid,
  input  logic [NumOfImages*ImageSize-1:0][BitSize-1:0] in_data,
  output logic                                          in_ready,
  input  logic                                          out_ready,
  output logic                                          out_valid,
  output logic                                          out_start,
  output logic                                          out_done,
  output logic [NumOfOutputs-1:0][BitSize-1:0]          out_data
);

  localparam int NumGroups = NumOfImages / NumOfOutputs;
  localparam int NumPix    = NumOfImages * ImageSize;
  localparam int PW        = cnt_w(ImageSize);
  localparam int GW        = cnt_w(NumGroups);

  unflat_state_t state_q, state_d;
  logic [NumPix-1:0][BitSize-1:0] buf_q;
  logic          capture, clear, run;
  logic [PW-1:0] pix;
  logic [GW-1:0] grp;
  logic          cyc_zero, last;

  unflat_seq #(
    .CyclesPerPixel(CyclesPerPixel),
    .ImageSize     (ImageSize),
    .NumGroups     (NumGroups)
  ) u_seq (
    .clk       (clk),
    .res       (res),
    .clear_i   (clear),
    .run_i     (run),
    .pix_o     (pix),
    .grp_o     (grp),
    .cyc_zero_o(cyc_zero),
    .last_o    (last)
  );

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    clear     = 1'b0;
    run       = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_start = 1'b0;
    out_done  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture = 1'b1;
          clear   = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        run       = out_ready;
        out_valid = cyc_zero && out_ready;
        out_start = cyc_zero && out_ready && (pix == '0);
        out_done  = last && out_ready;
        if (last && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the capture buffer is reset, so out_data is defined from the first cycle.
  always_ff @(posedge clk or posedge res) begin
    if (res)          buf_q <= '0;
    else if (capture) buf_q <= in_data;
  end

  // The compare-select keeps the index at full int width and never narrows it to an address.
  always_comb begin
    int idx;
    idx      = 0;
    out_data = '0;
    if (state_q == STREAM) begin
      for (int j = 0; j < NumOfOutputs; j++) begin
        idx = (int'(grp) * NumOfOutputs + j) * ImageSize + int'(pix);
        for (int k = 0; k < NumPix; k++) begin
          if (k == idx) out_data[j] = buf_q[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_unflattening_layer.sv
// Directed bench for unflattening_layer: default instance plus a CyclesPerPixel=1, 4-lane instance.
// Expected streams are derived from the step index of the unstalled replay.
module tb_unflattening_layer;

  localparam int NP = 36;
  typedef logic [NP-1:0][1:0] vec_t;

  logic       clk;
  logic       res;
  logic       in_valid, in_ready, out_ready, out_valid, out_start, out_done;
  vec_t       in_data;
  logic [1:0][1:0] out_data;
  logic       f_in_valid, f_in_ready, f_out_ready, f_out_valid, f_out_start, f_out_done;
  vec_t       f_in_data;
  logic [3:0][1:0] f_out_data;

  int pass_cnt;
  int total_cnt;

  unflattening_layer u_dut (
    .clk      (clk),
    .res      (res),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_start(out_start),
    .out_done (out_done),
    .out_data (out_data)
  );

  unflattening_layer #(
    .CyclesPerPixel(1),
    .NumOfOutputs  (4)
  ) u_fast (
    .clk      (clk),
    .res      (res),
    .in_valid (f_in_valid),
    .in_data  (f_in_data),
    .in_ready (f_in_ready),
    .out_ready(f_out_ready),
    .out_valid(f_out_valid),
    .out_start(f_out_start),
    .out_done (f_out_done),
    .out_data (f_out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk_vec(input int mul, input int add);
    vec_t v;
    for (int k = 0; k < NP; k++) v[k] = 2'((k * mul + add) % 4);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input vec_t v);
    in_valid  = 1'b1;
    in_data   = v;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  // Walks one default-instance stream from its first cycle; s is the unstalled step (0..71).
  task automatic run_stream(input string name, input vec_t v, input int stall_s, input int stall_len,
                            input bit hold, input vec_t hv, output int ncyc);
    int s, c, left, pix, grp;
    bit stalled;
    logic ev;
    logic [1:0][1:0] ed;
    logic [7:0] got, exp;
    s = 0; c = 0; left = stall_len;
    while (s < 72 && c < 200) begin
      stalled = (s == stall_s) && (left > 0);
      if (stalled) left--;
      out_ready = !stalled;
      if (hold) begin
        in_valid = 1'b1;
        in_data  = hv;
      end
      @(negedge clk);
      c++;
      pix = (s / 4) % 9;
      grp = s / 36;
      for (int j = 0; j < 2; j++) ed[j] = v[(grp * 2 + j) * 9 + pix];
      ev  = !stalled && (s % 4 == 0);
      exp = {1'b0, ev, ev && (pix == 0), !stalled && (s == 71), ed};
      got = {in_ready, out_valid, out_start, out_done, out_data};
      total_cnt++;
      if (got !== exp) $display("FAIL %s cycle %0d: got %h expected %h", name, c, got, exp);
      else pass_cnt++;
      if (!stalled) s++;
      tick();
    end
    out_ready = 1'b1;
    ncyc = c;
  endtask

  task automatic test_reset();
    res = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    f_in_valid = 1'b0; f_in_data = '0; f_out_ready = 1'b1;
    #12;
    total_cnt++;
    if ({in_ready, out_valid, out_start, out_done, out_data} !== 8'h80)
      $display("FAIL reset_state: got %h expected 80", {in_ready, out_valid, out_start, out_done, out_data});
    else pass_cnt++;
    total_cnt++;
    if ({f_in_ready, f_out_valid, f_out_start, f_out_done, f_out_data} !== 12'h800)
      $display("FAIL reset_state_fast: got %h expected 800",
               {f_in_ready, f_out_valid, f_out_start, f_out_done, f_out_data});
    else pass_cnt++;
    @(negedge clk);
    res = 1'b0;
    tick();
    @(negedge clk);
    total_cnt++;
    if ({in_ready, out_valid, out_data} !== 6'h20)
      $display("FAIL idle_after_reset: got %h expected 20", {in_ready, out_valid, out_data});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_basic();
    vec_t v;
    int n;
    v = mk_vec(1, 0);
    capture(v);
    run_stream("basic", v, -1, 0, 1'b0, v, n);
    total_cnt++;
    if (n !== 72) $display("FAIL basic_length: got %0d expected 72", n);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL basic_ready_after_done: got %b expected 10", {in_ready, out_valid});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_stall();
    vec_t v;
    int n;
    v = mk_vec(3, 1);
    capture(v);
    run_stream("stall", v, 12, 5, 1'b0, v, n);
    total_cnt++;
    if (n !== 77) $display("FAIL stall_length: got %0d expected 77", n);
    else pass_cnt++;
    @(negedge clk);
    tick();
  endtask

  task automatic test_hold_valid_back_to_back();
    vec_t v1, v2;
    int n;
    v1 = mk_vec(1, 2);
    v2 = mk_vec(3, 0);
    capture(v1);
    run_stream("hold_valid", v1, -1, 0, 1'b1, v2, n);
    total_cnt++;
    if (n !== 72) $display("FAIL hold_valid_length: got %0d expected 72", n);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL b2b_ready: got %b expected 1", in_ready);
    else pass_cnt++;
    tick();
    in_valid = 1'b0;
    run_stream("back_to_back", v2, -1, 0, 1'b0, v2, n);
    total_cnt++;
    if (n !== 72) $display("FAIL b2b_length: got %0d expected 72", n);
    else pass_cnt++;
    @(negedge clk);
    tick();
  endtask

  task automatic test_reset_mid();
    vec_t v, v2;
    int n;
    v  = mk_vec(1, 0);
    v2 = mk_vec(1, 1);
    capture(v);
    repeat (29) tick();
    #1;
    total_cnt++;
    if ({in_ready, out_valid, out_start, out_done, out_data} !== 8'h03)
      $display("FAIL pre_reset_cycle30: got %h expected 03", {in_ready, out_valid, out_start, out_done, out_data});
    else pass_cnt++;
    res = 1'b1;
    #1;
    total_cnt++;
    if ({in_ready, out_valid, out_start, out_done, out_data} !== 8'h80)
      $display("FAIL async_reset: got %h expected 80", {in_ready, out_valid, out_start, out_done, out_data});
    else pass_cnt++;
    @(negedge clk);
    res = 1'b0;
    tick();
    capture(v2);
    run_stream("post_reset", v2, -1, 0, 1'b0, v2, n);
    total_cnt++;
    if (n !== 72) $display("FAIL post_reset_length: got %0d expected 72", n);
    else pass_cnt++;
    @(negedge clk);
    tick();
  endtask

  task automatic test_cpp1();
    vec_t fv;
    logic [3:0][1:0] ed;
    logic [11:0] got, exp;
    fv = mk_vec(1, 3);
    f_in_valid = 1'b1;
    f_in_data  = fv;
    tick();
    f_in_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++) ed[j] = fv[j * 9 + c - 1];
      exp = {1'b0, 1'b1, c == 1, c == 9, ed};
      got = {f_in_ready, f_out_valid, f_out_start, f_out_done, f_out_data};
      total_cnt++;
      if (got !== exp) $display("FAIL cpp1 cycle %0d: got %h expected %h", c, got, exp);
      else pass_cnt++;
      tick();
    end
    @(negedge clk);
    total_cnt++;
    if ({f_in_ready, f_out_valid} !== 2'b10) $display("FAIL cpp1_idle: got %b expected 10", {f_in_ready, f_out_valid});
    else pass_cnt++;
    tick();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_basic();
    test_stall();
    test_hold_valid_back_to_back();
    test_cpp1();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/unflattening_layer.md
# unflattening_layer

Reshapes a flat activation vector into per-image pixel streams, the reverse of the flattening stage. It captures one `NumOfImages*ImageSize`-pixel vector, for example from a dense layer, and replays it in raster order. The output goes on `NumOfOutputs` parallel lanes, paced at `CyclesPerPixel` cycles per pixel, so the stream can feed a convolution or pooling stage that expects the flattening layer's input timing.

## Interface
- `BitSize`, 2: bits per pixel.
- `ImageSize`, 9: pixels per image.
- `NumOfImages`, 4: images in the flat vector. Must be a multiple of `NumOfOutputs`.
- `NumOfOutputs`, 2: parallel output lanes.
- `CyclesPerPixel`, 4: cycles each pixel is held. Must be ≥ 1.

Ports:
- `clk`, input, 1: the single clock; all state is updated on its rising edge.
- `res`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: a flat vector is presented.
- `in_data`, input, `[NumOfImages*ImageSize-1:0][BitSize-1:0]`: the flat vector. Pixel p of image m is `in_data[m*ImageSize+p]`.
- `in_ready`, output, 1: the block can capture a vector.
- `out_ready`, input, 1: the downstream stage accepts output. When low, the stream stalls.
- `out_valid`, output, 1: one-cycle pulse on the first cycle of each pixel period.
- `out_start`, output, 1: pulse coincident with the `out_valid` of the first pixel of each group.
- `out_done`, output, 1: pulse on the final cycle of the final pixel of the final group.
- `out_data`, output, `[NumOfOutputs-1:0][BitSize-1:0]`: the current pixel on each lane.

## Operation
- Groups: NG = `NumOfImages/NumOfOutputs`. During group g, lane j carries image `g*NumOfOutputs+j`.
- FSM states: IDLE, STREAM.
  - IDLE: `in_ready`=1. If `in_valid` is 1, capture `in_data` into the buffer, clear all counters and move to STREAM.
  - STREAM: `in_ready`=0 and `in_valid` is ignored. Three counters run:
    - cyc: 0..`CyclesPerPixel`-1.
    - pix: 0..`ImageSize`-1.
    - grp: 0..NG-1.
  - Counter advance, only in cycles where `out_ready`=1:
    - cyc increments and wraps to 0.
    - When cyc wraps, pix increments.
    - When pix wraps, grp increments.
  - When cyc, pix and grp are all at their maximum and `out_ready`=1: assert `out_done` and return to IDLE.
- `out_data[j]` = `buffer[(grp*NumOfOutputs+j)*ImageSize+pix]` in STREAM. It is 0 in IDLE.
- `out_valid` = STREAM & (cyc==0) & `out_ready`.
- `out_start` = `out_valid` & (pix==0).
- Counter widths are `$clog2(max)+1` bits. Index arithmetic is unsigned and computed at full width. No truncation is permitted.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_start`=0, `out_done`=0, `out_data`=0.
  - State is IDLE, all counters are 0, the buffer is 0.
- Latency: a vector captured at edge t produces its first `out_valid` in the cycle after t, provided `out_ready`=1.
- Stream length with no stalls: `ImageSize`·NG·`CyclesPerPixel` cycles.
- The earliest next capture is the cycle after the `out_done` pulse, when `in_ready` has returned to 1. There is no same-cycle overlap.
- `out_ready` low:
  - All counters and outputs freeze.
  - `out_data` holds its value.
  - `out_valid`, `out_start` and `out_done` are suppressed.
  - On the release cycle, the block resumes from the frozen position.
- `CyclesPerPixel`=1: `out_valid` is high on every unstalled STREAM cycle.
- NG=1: there is a single group, so `out_start` fires once per vector.
- Reset asserted mid-stream: the block returns to IDLE asynchronously. All outputs go to their reset values immediately and the partial stream is discarded.

## Structure
- Shared package `cnn_pkg` holds:
  - typedef `unflat_state_t` with states IDLE and STREAM.
  - function `cnt_w(n)` returning `$clog2(n)+1`.
- One sub-module, `unflat_seq`, is natural. It contains the cascaded cyc/pix/grp counters with stall input and wrap flags, and exports pix, grp, cyc==0 and last.
- The top level holds the FSM, the capture buffer and the output mux.

## Test plan
All scenarios use default parameters unless stated otherwise.
- **Basic capture:** set `in_data[k]=k%4` and pulse `in_valid`.
  - 18 `out_valid` pulses follow, 4 cycles apart.
  - Group 0: lane0 carries images 0 pixels 0..8, lane1 carries image 1.
  - Group 1 carries images 2 and 3.
  - `out_done` fires 72 cycles after capture, and `in_ready` is 1 on the next cycle.
- **Stall:** hold `out_ready`=0 for 5 cycles at pix=3.
  - `out_data` is stable throughout and no pulses occur.
  - The stream ends at cycle 77.
- **`in_valid` held high in STREAM:**
  - The buffer is unchanged and `in_ready` stays 0.
  - A second vector is captured on the first cycle `in_ready` returns to 1.
- **Single cycle per pixel (`CyclesPerPixel`=1, `NumOfOutputs`=4):**
  - `out_valid` is high for 9 consecutive cycles.
  - `out_start` fires on the first of them.
  - `out_done` fires on the 9th.
- **Reset mid-stream:** assert `res` at cycle 30.
  - All outputs go to 0 and `in_ready` goes to 1 without waiting for a clock edge.
  - After `res` is deasserted and a new vector is captured, a full 72-cycle stream follows.
- **Back-to-back vectors:** present a new vector when `in_ready` rises.
  - The first `out_valid` of the second vector comes 2 cycles after the first vector's `out_done`.
